// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 12;

    // Wide enough for a counter load of RD_LAT-1 with RD_LAT up to 7.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Owner encoding; also the bit index of each requester in req[1:0].
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_EXT  = 1'b1;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-input picker: req[0] = core, req[1] = external port.
// When DM_ARB_CORE_PRIO_EN is defined the core wins every tie; otherwise a tie
// goes to the requester that did not own the previous access.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

`ifdef DM_ARB_CORE_PRIO_EN
    // last_owner is kept on the interface so the top is identical in both builds.
    logic unused_last;
    assign unused_last = last_owner;
`endif

    // Resolve the winner; a lone requester always wins.
    always_comb begin
        winner = OWN_CORE;
        case (req)
            2'b01:   winner = OWN_CORE;
            2'b10:   winner = OWN_EXT;
`ifdef DM_ARB_CORE_PRIO_EN
            2'b11:   winner = OWN_CORE;
`else
            2'b11:   winner = (last_owner == OWN_CORE) ? OWN_EXT : OWN_CORE;
`endif
            default: winner = OWN_CORE;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the processor core and an external port.
// One access at a time: IDLE samples requests, ACCESS drives the memory strobe
// for one cycle, WAIT counts out the read latency and returns registered data.
// Optional macro DM_ARB_CORE_PRIO_EN: core always wins a tie (see rr_arb2).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1             // 1..7 cycles from mem_en to valid mem_rdata
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    // WAIT is entered one cycle after mem_en, so it runs RD_LAT cycles total.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              last_owner, last_owner_n;
    logic              owner, owner_n;
    logic              winner;

    logic              core_gnt_n, ext_gnt_n;
    logic              core_rvalid_n, ext_rvalid_n;
    logic [DATA_W-1:0] core_rdata_n, ext_rdata_n;
    logic              mem_en_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic              busy_n;

    rr_arb2 u_pick (
        .req        ({ext_req, core_req}),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Next state, command latch and read-data return; every output is a register.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        last_owner_n  = last_owner;
        owner_n       = owner;
        core_gnt_n    = 1'b0;
        ext_gnt_n     = 1'b0;
        core_rvalid_n = 1'b0;
        ext_rvalid_n  = 1'b0;
        core_rdata_n  = core_rdata;
        ext_rdata_n   = ext_rdata;
        mem_en_n      = 1'b0;
        mem_we_n      = 1'b0;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;

        case (state)
            IDLE: begin
                if (core_req || ext_req) begin
                    state_n      = ACCESS;
                    owner_n      = winner;
                    last_owner_n = winner;
                    mem_en_n     = 1'b1;
                    if (winner == OWN_CORE) begin
                        core_gnt_n  = 1'b1;
                        mem_we_n    = core_we;
                        mem_addr_n  = core_addr;
                        mem_wdata_n = core_wdata;
                    end else begin
                        ext_gnt_n   = 1'b1;
                        mem_we_n    = ext_we;
                        mem_addr_n  = ext_addr;
                        mem_wdata_n = ext_wdata;
                    end
                end
            end

            ACCESS: begin
                // mem_we still holds the command being issued this cycle.
                if (mem_we) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = CNT_LOAD;
                    state_n = WAIT;
                end
            end

            WAIT: begin
                if (cnt == '0) begin
                    // mem_rdata is valid this cycle; only the owner's register moves.
                    state_n = IDLE;
                    if (owner == OWN_CORE) begin
                        core_rdata_n  = mem_rdata;
                        core_rvalid_n = 1'b1;
                    end else begin
                        ext_rdata_n  = mem_rdata;
                        ext_rvalid_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_owner  <= OWN_EXT;
            owner       <= OWN_CORE;
            core_gnt    <= 1'b0;
            ext_gnt     <= 1'b0;
            core_rvalid <= 1'b0;
            ext_rvalid  <= 1'b0;
            core_rdata  <= '0;
            ext_rdata   <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_owner  <= last_owner_n;
            owner       <= owner_n;
            core_gnt    <= core_gnt_n;
            ext_gnt     <= ext_gnt_n;
            core_rvalid <= core_rvalid_n;
            ext_rvalid  <= ext_rvalid_n;
            core_rdata  <= core_rdata_n;
            ext_rdata   <= ext_rdata_n;
            mem_en      <= mem_en_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            busy        <= busy_n;
        end
    end

endmodule
